// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB 3-phase write master.
package sccb_pkg;

  typedef enum logic [2:0] {IDLE, START, TX, XBIT, STOP, GAP} sccb_state_e;

  localparam int         QW            = 2;        // quarter-phase counter width
  localparam logic [7:0] DEF_CAMERA_ID = 8'h42;    // OV7670 write ID
  localparam int         TXN_QUARTERS  = 120;      // START + 27 bit slots + STOP + GAP

  // Pad levels for one quarter
  typedef struct packed {
    logic d;
    logic c;
    logic oe;
  } sccb_pins_t;

  // Bus levels for a given state/quarter; b is the data bit of the current TX slot
  function automatic sccb_pins_t pins_for(sccb_state_e st, logic [QW-1:0] q, logic b);
    sccb_pins_t p;
    p = '{d: 1'b1, c: 1'b1, oe: 1'b1};
    case (st)
      START: begin p.d = (q < 2'd2);  p.c = (q != 2'd3); end
      TX:    begin p.d = b;           p.c = q[1];        end
      XBIT:  begin p.d = 1'b0;        p.c = q[1]; p.oe = 1'b0; end
      STOP:  begin p.d = q[1];        p.c = (q != 2'd0); end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-phase divider: 1-cycle tick every DIV clocks, restartable by clr.
module sccb_tick_gen #(
  parameter int DIV = 62
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  // Free-running modulo-DIV counter, restarted on reset or clear
  always_ff @(posedge clk) begin
    if (!rstn || clr) cnt <= '0;
    else if (tick)    cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/sccb_master.sv
// SCCB 3-phase write master: ID, sub-address, data bytes on SIO_C/SIO_D.
// Optional feature macro: SCCB_ACK_CHECK_EN (samples ACK slots, reports NACK).
module sccb_master
  import sccb_pkg::*;
#(
  parameter int         CLK_FREQ  = 25000000,
  parameter int         SCCB_FREQ = 100000,
  parameter logic [7:0] CAMERA_ID = DEF_CAMERA_ID
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] address,
  input  logic [7:0] data,
  output logic       ready,
  output logic       sio_c,
  output logic       sio_d_out,
  output logic       sio_d_oe,
  input  logic       sio_d_in,
  output logic       nack_err
);
  localparam int DIV = CLK_FREQ / (4 * SCCB_FREQ);

  sccb_state_e   state, state_n;
  logic [QW-1:0] q, q_n;
  logic [2:0]    bit_idx, bit_n;
  logic [1:0]    byte_idx, byte_n;
  logic [7:0]    addr_q, data_q, byte_sel;
  logic          tick, accept;
  sccb_pins_t    pins;

  assign accept = start && ready;

  sccb_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .clr  (accept),
    .tick (tick)
  );

  // Next state/quarter/bit position; one quarter per tick
  always_comb begin
    state_n = state;
    q_n     = q;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    if (accept) begin
      state_n = START;
      q_n     = '0;
    end else if (tick && state != IDLE) begin
      q_n = q + 2'd1;
      if (q == 2'd3) begin
        case (state)
          START: begin state_n = TX; bit_n = 3'd7; byte_n = 2'd0; end
          TX:    if (bit_idx == 3'd0) state_n = XBIT;
                 else                 bit_n   = bit_idx - 3'd1;
          XBIT:  if (byte_idx == 2'd2) state_n = STOP;
                 else begin state_n = TX; bit_n = 3'd7; byte_n = byte_idx + 2'd1; end
          STOP:  state_n = GAP;
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // Byte being shifted in the upcoming slot
  always_comb begin
    case (byte_n)
      2'd0:    byte_sel = CAMERA_ID;
      2'd1:    byte_sel = addr_q;
      default: byte_sel = data_q;
    endcase
  end

  assign pins = pins_for(state_n, q_n, byte_sel[bit_n]);

  // FSM state plus registered pad/handshake outputs derived from the next state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      q         <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      ready     <= 1'b1;
      sio_c     <= 1'b1;
      sio_d_out <= 1'b1;
      sio_d_oe  <= 1'b1;
    end else begin
      state     <= state_n;
      q         <= q_n;
      bit_idx   <= bit_n;
      byte_idx  <= byte_n;
      ready     <= (state_n == IDLE);
      sio_c     <= pins.c;
      sio_d_out <= pins.d;
      sio_d_oe  <= pins.oe;
      if (accept) begin
        addr_q <= address;
        data_q <= data;
      end
    end
  end

`ifdef SCCB_ACK_CHECK_EN
  // Sample the ACK slot at the end of its high-clock quarter; sticky until next accept
  always_ff @(posedge clk) begin
    if (!rstn || accept)                                   nack_err <= 1'b0;
    else if (state == XBIT && q == 2'd2 && tick && sio_d_in) nack_err <= 1'b1;
  end
`else
  logic unused_sio_d_in;
  assign unused_sio_d_in = sio_d_in;
  assign nack_err        = 1'b0;
`endif

endmodule

// File: doc/sccb_master.md
# sccb_master

SCCB (OV7670 serial camera control bus) 3-phase write master. Sits directly downstream of the camera configuration sequencer. It accepts one register address/data pair per handshake and serialises it onto SIO_C/SIO_D as an ID byte, a sub-address byte and a data byte. It signals `ready` when the bus is free for the next command.

## Interface
- `CLK_FREQ`, 25000000: system clock frequency in Hz.
- `SCCB_FREQ`, 100000: SIO_C frequency in Hz. The quarter-period divider is `DIV = CLK_FREQ/(4*SCCB_FREQ)`, rounded down, and must be ≥ 2 (default 62).
- `CAMERA_ID`, 8'h42: device write ID sent as the first byte.
- `clk`  in  1  system clock; the only clock.
- `rstn`  in  1  synchronous, active-low reset.
- `start`  in  1  command request; sampled only while `ready`=1.
- `address`  in  8  camera register sub-address.
- `data`  in  8  register write value.
- `ready`  out  1  idle and able to accept `start`.
- `sio_c`  out  1  SCCB clock, push-pull.
- `sio_d_out`  out  1  SCCB data drive value.
- `sio_d_oe`  out  1  SCCB data output enable (1 = drive `sio_d_out`; 0 = release).
- `sio_d_in`  in  1  SCCB data pad input; used only with `SCCB_ACK_CHECK_EN`.
- `nack_err`  out  1  the last transaction saw a NACK; held 0 without `SCCB_ACK_CHECK_EN`.

## Operation
- Reset values: `ready`=1, `sio_c`=1, `sio_d_out`=1, `sio_d_oe`=1, `nack_err`=0, state IDLE, divider 0.
- Accept: `start`=1 and `ready`=1 on a rising edge.
  - `address` and `data` are latched.
  - `ready`=0 from the next cycle.
  - The divider restarts.
  - `nack_err` clears.
- `start` while `ready`=0 is ignored and is not queued.
- Every state advances one quarter-phase per divider tick, i.e. every DIV clocks. The phase counter q runs 0..3.
- States: IDLE → START → TX → XBIT → (TX | STOP) → GAP → IDLE.
- START (4 quarters), as (sio_d_out, sio_c) per quarter: q0 (1,1), q1 (1,1), q2 (0,1), q3 (0,0).
- TX: 8 bits, MSB first. Byte order is `CAMERA_ID`, `address`, `data`.
  - Per bit: q0 sio_c=0 and sio_d_out updates; q1 sio_c=0; q2 sio_c=1; q3 sio_c=1.
  - `sio_d_oe`=1 throughout.
- XBIT: one bit slot with the same sio_c pattern as TX and `sio_d_oe`=0.
  - After byte 0 or 1 → TX of the next byte.
  - After byte 2 → STOP.
- STOP: q0 (0,0), q1 (0,1), q2 (1,1), q3 (1,1). `sio_d_oe`=1 from q0.
- GAP: 4 quarters bus-free with (1,1), then IDLE with `ready`=1.
- Reset asserted mid-transaction: on the next edge all outputs take their reset values and any pending command is dropped. No stop sequence is generated.

## Timing
- Transaction length is 120 quarters: START 4 + 27 bit slots × 4 + STOP 4 + GAP 4.
- `ready` rises exactly 120·DIV clock cycles after the accept edge. With defaults this is 7440 cycles.
- `ready` falls on the cycle after the accept edge. An upstream sequencer that waits one cycle then re-checks `ready` therefore never double-issues.
- `sio_d_out` changes only while `sio_c`=0, except in the START and STOP quarters.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `SCCB_ACK_CHECK_EN` defined:
  - `sio_d_in` is sampled on the last clock of q2 of each XBIT.
  - A sample of 1 sets `nack_err`.
  - `nack_err` holds until the next accept or reset.
  - The transaction always completes; there is no abort.
- Not defined: `sio_d_in` is unused, `nack_err` is constant 0, and XBIT is don't-care.

## Structure
- `sccb_pkg`: state enum (IDLE, START, TX, XBIT, STOP, GAP), quarter-phase width, default `CAMERA_ID`, transaction quarter count (120).
- Sub-module `sccb_tick_gen`: DIV counter with a synchronous clear.
  - Emits a 1-cycle `tick` every DIV clocks.
  - Cleared on accept and on reset.

## Test plan
- Reset: hold `rstn`=0 for 5 cycles → `ready`=1, `sio_c`=1, `sio_d_out`=1, `sio_d_oe`=1, `nack_err`=0.
- Single write: `address`=8'h12, `data`=8'h80 with a 1-cycle `start`.
  - Decoded bus carries bytes 42, 12, 80, with start and stop conditions.
  - `ready` low for exactly 7440 cycles.
- Busy ignore: pulse `start` with 8'hAA/8'h55 at cycle 100 of a transaction → no second transaction occurs and the bus bytes are unchanged.
- Back-to-back: assert `start` on the same cycle `ready` rises with 8'h11/8'h01 → the next START begins immediately; two complete frames are seen with 4 bus-free quarters between them.
- Mid-reset: drop `rstn` during the `address` byte → the next edge shows idle outputs; a subsequent write of 8'h40/8'hD0 completes correctly.
- `SCCB_ACK_CHECK_EN`: the model drives `sio_d_in`=1 in the second XBIT → `nack_err`=1 after the transaction; it clears on the next accept with all-ACK.
